// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared UART receive definitions: FSM state encoding, prescale floor, parity-mode encodings.
package uart_rx_frame_ctrl_pkg;

  localparam int unsigned MIN_PRESCALE = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } rx_state_e;

  function automatic int unsigned eff_prescale(input int unsigned p);
    return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with 3-sample majority vote around the bit centre.
module uart_rx_sampler #(
  parameter int PRE_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             rx_in,
  input  logic [PRE_W-1:0] p,
  output logic             bit_val,
  output logic             strobe,
  output logic             bit_end
);

  localparam logic [PRE_W-1:0] ONE = PRE_W'(1);
  localparam logic [PRE_W-1:0] TWO = PRE_W'(2);

  logic [PRE_W-1:0] edge_cnt;
  logic [PRE_W-1:0] half;
  logic [2:0]       smp;
  logic             smp_en;

  assign half    = p >> 1;
  assign smp_en  = run && ((edge_cnt == half - ONE) || (edge_cnt == half) || (edge_cnt == half + ONE));
  assign strobe  = run && (edge_cnt == half + TWO);
  assign bit_end = run && (edge_cnt == p - ONE);
  assign bit_val = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  // Counter parks at 0 while idle so START always begins at edge 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      smp      <= '0;
    end else begin
      if (!run)         edge_cnt <= '0;
      else if (bit_end) edge_cnt <= '0;
      else              edge_cnt <= edge_cnt + ONE;
      if (smp_en) smp <= {smp[1:0], rx_in};
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive controller: frame FSM, bit counting, deserialisation, parity and stop checks.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PRE_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic [PRE_W-1:0]  prescale,
  input  logic              par_en,
  input  logic              par_odd,
  input  logic              two_stop,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              par_err,
  output logic              frm_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_e         state, state_nx;
  logic [PRE_W-1:0]  p_q;
  logic              par_en_q, par_odd_q, two_stop_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bad, frm_bad, frm_now, exp_par;
  logic              bit_val, strobe, bit_end;
  logic              start_det, finish;

  assign busy      = (state != IDLE);
  assign start_det = (state == IDLE) && !rx_in;
  assign exp_par   = (par_odd_q == PAR_ODD) ? ~^shreg : ^shreg;
  assign frm_now   = frm_bad | (strobe & ~bit_val);

  uart_rx_sampler #(.PRE_W(PRE_W)) u_sampler (
    .clk     (clk),
    .rst     (rst),
    .run     (busy),
    .rx_in   (rx_in),
    .p       (p_q),
    .bit_val (bit_val),
    .strobe  (strobe),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    finish   = 1'b0;
    unique case (state)
      IDLE:   if (!rx_in) state_nx = START;
      START:  if (strobe && bit_val) state_nx = IDLE;
              else if (bit_end)      state_nx = DATA;
      DATA:   if (bit_end && bit_cnt == LAST_BIT) state_nx = par_en_q ? PARITY : STOP1;
      PARITY: if (bit_end) state_nx = STOP1;
      STOP1:  if (two_stop_q) begin
                if (bit_end) state_nx = STOP2;
              end else if (strobe) begin
                finish   = 1'b1;
                state_nx = IDLE;
              end
      STOP2:  if (strobe) begin
                finish   = 1'b1;
                state_nx = IDLE;
              end
      default: state_nx = IDLE;
    endcase
  end

  // Frame config is frozen at the start edge; mid-frame input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q        <= PRE_W'(MIN_PRESCALE);
      par_en_q   <= 1'b0;
      par_odd_q  <= PAR_EVEN;
      two_stop_q <= 1'b0;
    end else if (start_det) begin
      p_q        <= PRE_W'(eff_prescale(32'(prescale)));
      par_en_q   <= par_en;
      par_odd_q  <= par_odd;
      two_stop_q <= two_stop;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      frm_bad  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      if (start_det) begin
        bit_cnt <= '0;
        par_bad <= 1'b0;
        frm_bad <= 1'b0;
      end
      if (state == DATA && strobe)  shreg   <= {bit_val, shreg[DATA_W-1:1]};
      if (state == DATA && bit_end) bit_cnt <= bit_cnt + CNT_W'(1);
      if (state == PARITY && strobe) par_bad <= (bit_val != exp_par);
      if ((state == STOP1 || state == STOP2) && strobe && !bit_val) frm_bad <= 1'b1;
      if (finish) begin
        rx_valid <= !par_bad && !frm_now;
        par_err  <= par_bad;
        frm_err  <= frm_now;
        if (!par_bad && !frm_now) rx_data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench: frames are serialised onto the line, expected outcomes queued, popped on output pulses.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0, rst = 1'b0, rx8 = 1'b1, rx7 = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0, par_odd = 1'b0, two_stop = 1'b0;
  logic [7:0] d8;
  logic [6:0] d7;
  logic       v8, pe8, fe8, b8, v7, pe7, fe7, b7;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame_ctrl #(.DATA_W(8), .PRE_W(6)) dut8 (
    .clk(clk), .rst(rst), .rx_in(rx8), .prescale(prescale), .par_en(par_en),
    .par_odd(par_odd), .two_stop(two_stop), .rx_data(d8), .rx_valid(v8),
    .par_err(pe8), .frm_err(fe8), .busy(b8));

  uart_rx_frame_ctrl #(.DATA_W(7), .PRE_W(6)) dut7 (
    .clk(clk), .rst(rst), .rx_in(rx7), .prescale(prescale), .par_en(par_en),
    .par_odd(par_odd), .two_stop(two_stop), .rx_data(d7), .rx_valid(v7),
    .par_err(pe7), .frm_err(fe7), .busy(b7));

  typedef struct {
    logic [2:0] kind;   // {valid, par_err, frm_err}
    logic [8:0] data;
    int         due;
  } exp_t;

  exp_t       q8[$], q7[$];
  int         n_chk = 0, n_fail = 0;
  logic [8:0] last8 = '0, last7 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (v8 | pe8 | fe8) begin
      if (q8.size() == 0) chk("unexpected_pulse8", 32'({v8, pe8, fe8}), 32'd0);
      else begin
        e = q8.pop_front();
        chk("kind8", 32'({v8, pe8, fe8}), 32'(e.kind));
        chk("data8", 32'(d8), 32'(e.data));
        chk("lat8", 32'(cyc), 32'(e.due));
      end
    end
    if (v7 | pe7 | fe7) begin
      if (q7.size() == 0) chk("unexpected_pulse7", 32'({v7, pe7, fe7}), 32'd0);
      else begin
        e = q7.pop_front();
        chk("kind7", 32'({v7, pe7, fe7}), 32'(e.kind));
        chk("data7", 32'(d7), 32'(e.data));
        chk("lat7", 32'(cyc), 32'(e.due));
      end
    end
    if (cyc > 50000) begin
      $display("FAIL timeout cycle=%0d limit=50000", cyc);
      $fatal(1, "bench timeout");
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_data8"}, 32'(d8), 32'd0);
    chk({tag, "_pulses8"}, 32'({v8, pe8, fe8}), 32'd0);
    chk({tag, "_busy8"}, 32'(b8), 32'd0);
  endtask

  // Caller must be #1 after a posedge; each bit is held for pl cycles.
  task automatic send(input bit sel7, input logic [8:0] data, input bit pe, input bit po,
                      input bit ts, input bit flip, input bit s1, input bit s2,
                      input int pl, input logic [5:0] pafter, input int abort);
    int          dw, n;
    logic [12:0] bits;
    logic        pb, ok;
    logic [8:0]  dm;
    exp_t        e;
    dw = sel7 ? 7 : 8;
    dm = sel7 ? (data & 9'h07F) : (data & 9'h0FF);
    bits = '1;
    bits[0] = 1'b0;
    pb = po;
    for (int i = 0; i < dw; i++) begin
      bits[1 + i] = dm[i];
      pb ^= dm[i];
    end
    pb ^= flip;
    n = 1 + dw;
    if (pe) begin bits[n] = pb; n++; end
    bits[n] = s1; n++;
    if (ts) begin bits[n] = s2; n++; end
    ok = !(pe && flip) && s1 && (!ts || s2);
    e.kind = {ok, pe && flip, !s1 || (ts && !s2)};
    e.due  = cyc + (n - 1) * pl + pl / 2 + 4;
    if (sel7) begin
      if (ok) last7 = dm;
      e.data = last7;
    end else begin
      if (ok) last8 = dm;
      e.data = last8;
    end
    if (abort < 0) begin
      if (sel7) q7.push_back(e);
      else      q8.push_back(e);
    end
    for (int b = 0; b < n; b++) begin
      if (b == abort) begin
        rst = 1'b0; rx8 = 1'b1; rx7 = 1'b1;
        gap(3);
        chk_quiet("in_reset");
        rst = 1'b1;
        gap(2 * pl);
        chk_quiet("after_reset");
        last8 = '0;
        return;
      end
      if (sel7) rx7 = bits[b];
      else      rx8 = bits[b];
      if (b == 1) prescale = pafter;
      gap(pl);
    end
    rx8 = 1'b1;
    rx7 = 1'b1;
  endtask

  initial begin
    gap(3);
    chk_quiet("reset");
    chk("reset_data7", 32'(d7), 32'd0);
    chk("reset_busy7", 32'(b7), 32'd0);
    rst = 1'b1;
    gap(2);
    fork
      forever begin @(negedge clk); mon(); end
    join_none

    // 8N1 at P=8
    send(0, 9'hA5, 0, 0, 0, 0, 1, 1, 8, 6'd8, -1);
    gap(40);
    // 8E1 at P=16: wrong then correct parity
    prescale = 6'd16; par_en = 1'b1; par_odd = 1'b0;
    send(0, 9'h3C, 1, 0, 0, 1, 1, 1, 16, 6'd16, -1);
    gap(60);
    send(0, 9'h3C, 1, 0, 0, 0, 1, 1, 16, 6'd16, -1);
    gap(60);
    // 7O2 at P=8: bad second stop, then good frame
    prescale = 6'd8; par_odd = 1'b1; two_stop = 1'b1;
    send(1, 9'h55, 1, 1, 1, 0, 1, 0, 8, 6'd8, -1);
    gap(40);
    send(1, 9'h55, 1, 1, 1, 0, 1, 1, 8, 6'd8, -1);
    gap(40);
    // 8O2: wrong parity and low first stop -> both errors together
    send(0, 9'h81, 1, 1, 1, 1, 0, 1, 8, 6'd8, -1);
    gap(40);

    // start glitch: low for 2 cycles only
    par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
    rx8 = 1'b0;
    gap(2);
    rx8 = 1'b1;
    chk("glitch_busy_hi", 32'(b8), 32'd1);
    gap(8);
    chk("glitch_busy_lo", 32'(b8), 32'd0);
    gap(20);

    // prescale floor, then mid-frame change 8->16, then next frame at 16
    prescale = 6'd4;
    send(0, 9'h96, 0, 0, 0, 0, 1, 1, 8, 6'd4, -1);
    gap(40);
    prescale = 6'd8;
    send(0, 9'h4B, 0, 0, 0, 0, 1, 1, 8, 6'd16, -1);
    gap(40);
    send(0, 9'hC3, 0, 0, 0, 0, 1, 1, 16, 6'd16, -1);
    gap(60);

    // back-to-back at P=32, reset during the second frame
    prescale = 6'd32;
    send(0, 9'h000, 0, 0, 0, 0, 1, 1, 32, 6'd32, -1);
    send(0, 9'h0FF, 0, 0, 0, 0, 1, 1, 32, 6'd32, 4);
    gap(400);

    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q7_drained", 32'(q7.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
